// File: rtl/motor_pkg.sv
// Shared definitions for the stepper phase sequencer: commands, states and phase tables.
// Build option: define MOTOR_PASO_HALF_STEP_EN for the 8-phase half-step sequence.
package motor_pkg;

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_CW   = 2'b01;
    localparam logic [1:0] CMD_CCW  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DWELL = 2'd2
    } motor_state_e;

    localparam logic [3:0] FULL_TABLE [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    localparam logic [3:0] HALF_TABLE [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                              4'b0100, 4'b1100, 4'b1000, 4'b1001};

`ifdef MOTOR_PASO_HALF_STEP_EN
    localparam int NPH      = 8;
    localparam int POS_MULT = 2;
`else
    localparam int NPH      = 4;
    localparam int POS_MULT = 1;
`endif

    localparam int PH_W = $clog2(NPH);

    function automatic logic [3:0] phase_pattern(input logic [PH_W-1:0] ph);
`ifdef MOTOR_PASO_HALF_STEP_EN
        return HALF_TABLE[ph];
`else
        return FULL_TABLE[ph];
`endif
    endfunction

endpackage

// File: rtl/motor_paso_if.sv
// Command/feedback bundle between the tracking controller (master) and one axis sequencer (slave).
interface motor_paso_if #(
    parameter int POS_W = 16
);
    logic [1:0]       cmd;
    logic [3:0]       coils;
    logic             step;
    logic             dir;
    logic [POS_W-1:0] position;
    logic             busy;

    modport master (output cmd, input coils, step, dir, position, busy);
    modport slave  (input cmd, output coils, step, dir, position, busy);
endinterface

// File: rtl/divisor_paso.sv
// Step-period tick counter: counts 0..DIV-1 while enabled, synchronous clear, terminal-count flag.
module divisor_paso #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] tick_reg;

    assign tc = (tick_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tick_reg <= '0;
        end else if (en) begin
            tick_reg <= tc ? '0 : tick_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/motor_paso.sv
// Stepper-motor phase sequencer for one tracker axis, with wrapping step-position feedback.
// Build option: MOTOR_PASO_HALF_STEP_EN selects half-step (8 phases, 2*STEPS_PER_REV positions).
module motor_paso
    import motor_pkg::*;
#(
    parameter int STEP_DIV      = 50000,
    parameter int STEPS_PER_REV = 200,
    parameter int POS_W         = 16
) (
    input  logic           clk,
    input  logic           rst,
    motor_paso_if.slave    bus
);
    localparam int NPOS = POS_MULT * STEPS_PER_REV;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NPOS - 1);

    motor_state_e     state_reg;
    logic             dir_reg;
    logic             energised_reg;
    logic [PH_W-1:0]  phase_reg;
    logic [POS_W-1:0] position_reg;
    logic [3:0]       coils_reg;
    logic             step_reg;
    logic             busy_reg;

    logic [PH_W-1:0]  phase_next;
    logic [POS_W-1:0] position_next;
    logic             cmd_move;
    logic             cmd_rev;
    logic             leave_state;
    logic             tick_clr;
    logic             tick_tc;

    always_comb begin
        cmd_move = (bus.cmd == CMD_CW) || (bus.cmd == CMD_CCW);
        cmd_rev  = cmd_move && (bus.cmd[1] != dir_reg);
        leave_state = ((state_reg == ST_RUN)   && (!cmd_move || cmd_rev)) ||
                      ((state_reg == ST_DWELL) && (!cmd_move || tick_tc));
        tick_clr = (state_reg == ST_IDLE) || leave_state;

        // Target values of a step in the current direction; committed only when a step fires.
        phase_next = dir_reg ? phase_reg - PH_W'(1) : phase_reg + PH_W'(1);
        if (dir_reg) begin
            position_next = (position_reg == '0) ? POS_MAX : position_reg - POS_W'(1);
        end else begin
            position_next = (position_reg == POS_MAX) ? '0 : position_reg + POS_W'(1);
        end
    end

    divisor_paso #(
        .DIV (STEP_DIV)
    ) u_divisor (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .en  (!tick_clr),
        .tc  (tick_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            dir_reg       <= 1'b0;
            energised_reg <= 1'b0;
            phase_reg     <= '0;
            position_reg  <= '0;
            coils_reg     <= 4'b0000;
            step_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            step_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_move) begin
                        state_reg     <= ST_RUN;
                        dir_reg       <= bus.cmd[1];
                        energised_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        coils_reg     <= phase_pattern(phase_reg);
                    end
                end
                ST_RUN: begin
                    // Stop and reversal both take priority over a step due this cycle.
                    if (!cmd_move) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (cmd_rev) begin
                        state_reg <= ST_DWELL;
                    end else if (tick_tc) begin
                        phase_reg    <= phase_next;
                        position_reg <= position_next;
                        coils_reg    <= energised_reg ? phase_pattern(phase_next) : 4'b0000;
                        step_reg     <= 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (!cmd_move) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (tick_tc) begin
                        state_reg <= ST_RUN;
                        dir_reg   <= bus.cmd[1];
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.coils    = coils_reg;
    assign bus.step     = step_reg;
    assign bus.dir      = dir_reg;
    assign bus.position = position_reg;
    assign bus.busy     = busy_reg;
endmodule

// File: tb/tb_motor_paso.sv
// Self-checking bench for motor_paso: directed scenarios plus randomized command spans
// compared every cycle against a period-counting behavioural model.
module tb_motor_paso;
    localparam int DIV  = 4;
    localparam int SPR  = 8;
    localparam int PW   = 16;
`ifdef MOTOR_PASO_HALF_STEP_EN
    localparam int NPH  = 8;
    localparam int NPOS = 2 * SPR;
`else
    localparam int NPH  = 4;
    localparam int NPOS = SPR;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    motor_paso_if #(.POS_W(PW)) bus ();

    motor_paso #(
        .STEP_DIV      (DIV),
        .STEPS_PER_REV (SPR),
        .POS_W         (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] tab [8];
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: mode 0 idle, 1 moving, 2 reversal dead time; cnt = cycles into current period.
    int m_mode, m_cnt, m_ph, m_pos, m_dir, m_en, m_step;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input logic [1:0] c, input logic r);
        bit mv;
        mv = (c == 2'b01) || (c == 2'b11);
        m_step = 0;
        if (r) begin
            m_mode = 0; m_cnt = 0; m_ph = 0; m_pos = 0; m_dir = 0; m_en = 0;
        end else if (m_mode == 0) begin
            if (mv) begin
                m_mode = 1; m_dir = int'(c[1]); m_en = 1; m_cnt = 0;
            end
        end else if (!mv) begin
            m_mode = 0; m_cnt = 0;
        end else if (m_mode == 1) begin
            if (int'(c[1]) != m_dir) begin
                m_mode = 2; m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == DIV) begin
                    m_cnt  = 0;
                    m_step = 1;
                    m_ph   = (m_ph  + (m_dir ? NPH  - 1 : 1)) % NPH;
                    m_pos  = (m_pos + (m_dir ? NPOS - 1 : 1)) % NPOS;
                end
            end
        end else begin
            m_cnt++;
            if (m_cnt == DIV) begin
                m_mode = 1; m_dir = int'(c[1]); m_cnt = 0;
            end
        end
    endtask

    task automatic apply(input logic [1:0] c, input logic r);
        bus.cmd = c;
        rst     = r;
        @(posedge clk);
        model_edge(c, r);
        cyc++;
        #1;
        chk("coils",    32'(bus.coils),    m_en ? 32'(tab[m_ph]) : 32'd0);
        chk("step",     32'(bus.step),     32'(m_step));
        chk("dir",      32'(bus.dir),      32'(m_dir));
        chk("position", 32'(bus.position), 32'(m_pos));
        chk("busy",     32'(bus.busy),     32'(m_mode != 0));
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) apply(2'b01, 1'b1);
    endtask

    initial begin
        int busy_cyc, step_cyc, len;
        logic [1:0] c;
        bit r;
`ifdef MOTOR_PASO_HALF_STEP_EN
        tab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
`else
        tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
        m_mode = 0; m_cnt = 0; m_ph = 0; m_pos = 0; m_dir = 0; m_en = 0; m_step = 0;
        bus.cmd = 2'b00;
        rst = 1'b1;

        do_reset();
        $display("reset with cmd=01 held 3 cycles: coils=%b position=%0d busy=%b",
                 bus.coils, bus.position, bus.busy);

        busy_cyc = -1; step_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            apply(2'b01, 1'b0);
            if (bus.busy && busy_cyc < 0) busy_cyc = cyc;
            if (bus.step && step_cyc < 0) step_cyc = cyc;
        end
        chk("first_step_latency", 32'(step_cyc - busy_cyc), 32'd4);
        chk("cw_run_position", 32'(bus.position), 32'd4 % NPOS);
        $display("cw run 20 cycles: first step %0d cycles after busy, position=%0d",
                 step_cyc - busy_cyc, bus.position);

        do_reset();
        for (int i = 0; i < 5; i++) apply(2'b11, 1'b0);
        chk("ccw_wrap_position", 32'(bus.position), 32'(NPOS - 1));
        chk("ccw_wrap_coils", 32'(bus.coils), 32'(tab[NPH - 1]));
        $display("ccw wrap: position=%0d coils=%b", bus.position, bus.coils);

        do_reset();
        for (int i = 0; i < 7; i++) apply(2'b01, 1'b0);
        for (int i = 0; i < 14; i++) apply(2'b11, 1'b0);
        chk("reversal_dir", 32'(bus.dir), 32'd1);
        $display("reversal mid-period: position=%0d dir=%b", bus.position, bus.dir);

        do_reset();
        for (int i = 0; i < 4; i++) apply(2'b01, 1'b0);
        apply(2'b00, 1'b0);
        chk("race_step", 32'(bus.step), 32'd0);
        chk("race_position", 32'(bus.position), 32'd0);
        chk("race_coils", 32'(bus.coils), 32'(tab[0]));
        $display("stop race on terminal tick: step=%b position=%0d busy=%b coils=%b",
                 bus.step, bus.position, bus.busy, bus.coils);

        do_reset();
        for (int i = 0; i < 5; i++) apply(2'b11, 1'b0);
        for (int i = 0; i < 8 + 9 * DIV; i++) apply(2'b01, 1'b0);
        chk("walk_position", 32'(bus.position), 32'(8 % NPOS));
        $display("reverse then 9 cw steps: position=%0d coils=%b", bus.position, bus.coils);

        for (int i = 0; i < 6; i++) apply(2'b01, 1'b0);
        apply(2'b01, 1'b1);
        chk("midmove_reset_busy", 32'(bus.busy), 32'd0);
        $display("reset mid-move: coils=%b position=%0d", bus.coils, bus.position);

        for (int s = 0; s < 80; s++) begin
            c   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 14);
            r   = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < len; i++) apply(c, r && (i == 0));
        end
        $display("random spans done at cycle %0d: position=%0d", cyc, bus.position);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/motor_paso.md
# motor_paso

Stepper-motor phase sequencer for one tracker axis. Consumes the 2-bit movement command produced by the sun-tracking controller (one instance per axis: theta and phi) and turns it into a timed coil-energisation sequence. It also maintains a wrapping step-position counter usable as actual-angle feedback. Sits between the tracking controller and the external H-bridge/driver pins.

## Interface
- `STEP_DIV`, 50000: clock cycles per step period (≥2).
- `STEPS_PER_REV`, 200: full steps per mechanical revolution (≥2).
- `POS_W`, 16: width of the position counter; must hold `2*STEPS_PER_REV-1`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd`  in  2  movement command: 00 stop, 01 clockwise, 11 counter-clockwise, 10 reserved (treated as stop).
- `coils`  out  4  coil drive pattern, bit0 = coil A … bit3 = coil D.
- `step`  out  1  one-cycle pulse on every executed step.
- `dir`  out  1  direction of the current/last move: 0 CW, 1 CCW.
- `position`  out  POS_W  step count, 0 … `NPOS-1`, wrapping.
- `busy`  out  1  high in RUN or DWELL.

## Operation
- `NPOS` = `STEPS_PER_REV` (full-step) or `2*STEPS_PER_REV` (half-step build). `NPH` = 4 or 8 phases.
- Full-step table, index 0..3: 0001, 0010, 0100, 1000. Half-step table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- Step period counter `tick`: 0 … `STEP_DIV-1`. It is cleared on every state change.
- States:
  - IDLE:
    - `tick` held at 0.
    - `cmd` CW/CCW → RUN, `dir`←cmd[1], `energised`←1.
  - RUN:
    - `tick` counts up.
    - At `tick==STEP_DIV-1` execute one step, `tick`←0.
    - `cmd` stop/reserved → IDLE; no step that cycle.
    - `cmd` opposite to `dir` → DWELL; no step that cycle.
  - DWELL (reversal dead time):
    - `tick` counts up.
    - `cmd` stop/reserved → IDLE immediately.
    - At `tick==STEP_DIV-1`: → RUN with `dir`←cmd[1].
- Step execution:
  - CW: phase index +1 mod `NPH`, `position` +1 mod `NPOS`.
  - CCW: phase index −1 mod `NPH`, `position` −1 mod `NPOS`.
  - `position` wraps at both ends: `NPOS-1`→0 CW, 0→`NPOS-1` CCW.
- `coils` = `energised` ? table[phase] : 0000.
  - Coils stay energised on the last phase in IDLE (holding torque).
  - Only `rst` de-energises the coils.
- Stop requested on the same cycle a step would fire: stop wins, no step.
- `cmd` equal to `dir` in RUN: no effect on `tick`.

## Timing
- Reset values:
  - outputs: `coils`=0000, `step`=0, `dir`=0, `position`=0, `busy`=0
  - internal: phase index 0, `energised`=0, `tick`=0, state IDLE.
- `rst` mid-move: next cycle all of the above; no step issued on the reset cycle.
- `cmd` is sampled each rising edge.
- IDLE→RUN transition:
  - `busy` rises 1 cycle after `cmd` becomes non-stop.
  - `coils` shows table[current phase] from the same cycle `busy` rises.
- First step: `STEP_DIV` cycles after RUN entry. Subsequent steps: every `STEP_DIV` cycles.
- On a step, `coils`, `position` and `step` update together, one cycle after `tick==STEP_DIV-1` is registered.
- Reversal:
  - last old-direction step, then `STEP_DIV` cycles of DWELL
  - then RUN; first new-direction step `STEP_DIV` cycles after DWELL exit.
- All outputs are registered; no combinational input→output path.

## Configuration
- `MOTOR_PASO_HALF_STEP_EN`:
  - Defined: 8-phase half-step table, `NPOS`=`2*STEPS_PER_REV`.
  - Undefined: 4-phase full-step table, `NPOS`=`STEPS_PER_REV`.
  - Timing and interface are identical in both builds.

## Structure
- Shared package `motor_pkg`:
  - command encodings (`CMD_STOP`, `CMD_CW`, `CMD_CCW`)
  - state enum (IDLE, RUN, DWELL)
  - both phase tables as constant arrays.
- One sub-module, `divisor_paso`:
  - parameterised tick counter with synchronous clear
  - terminal-count output
  - instantiated once.

## Test plan
Bench parameters: `STEP_DIV`=4, `STEPS_PER_REV`=8, full-step unless stated.
- Reset: `rst` high 3 cycles with `cmd`=01 → `coils`=0000, `position`=0, `busy`=0, `step` never pulses during reset.
- CW run of 20 cycles from reset:
  - first `step` exactly 4 cycles after `busy` rises
  - `coils` sequence 0001→0010→0100→1000→0001
  - `position` 0→1→2→3→4.
- CCW wrap: from `position`=0, phase 0, `cmd`=11 → after one step `position`=7, `coils`=1000.
- Reversal: CW running, switch `cmd` to 11 mid-period:
  - no step for the partial period plus 4 DWELL cycles
  - next step decrements `position`; `dir`=1.
- Stop race: `cmd`→00 on the cycle `tick`=3 → no `step`, `position` unchanged, `busy` low next cycle, `coils` hold last pattern.
- Half-step build (`MOTOR_PASO_HALF_STEP_EN`), CW 9 steps:
  - `coils` walk 0001,0011,0010,0110,0100,1100,1000,1001,0001
  - `position` wraps 15→0 when started at 15.
